// File: rtl/toggle_cover_collector.sv
// Sticky toggle-cover collector: records first-time hits per epoch and streams
// each newly covered global index out once over a valid/ready port.
module toggle_cover_collector #(
  parameter int          WIDTH       = 32,
  parameter int unsigned COVER_INDEX = 0,
  parameter int          INDEX_W     = 64,
  localparam int         CNT_W       = $clog2(WIDTH + 1),
  localparam int         IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   valid,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic [CNT_W-1:0]   covered_count,
  output logic               all_covered
);

  logic [WIDTH-1:0]   seen_q, seen_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic               outValid_q, outValid_d;
  logic [INDEX_W-1:0] outIndex_q, outIndex_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               allCovered_q, allCovered_d;

  logic [WIDTH-1:0]   newHits;
  logic [WIDTH-1:0]   selMask;
  logic [IDX_W-1:0]   selIdx;
  logic               loadEn;

  function automatic logic [CNT_W-1:0] popCount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

  always_comb begin
    newHits = valid & ~seen_q;
    loadEn  = !outValid_q || out_ready;

    // Scan downward so the last match left in selIdx is the lowest set bit.
    selIdx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        selIdx = IDX_W'(i);
      end
    end

    selMask      = '0;
    seen_d       = seen_q;
    pending_d    = pending_q;
    outValid_d   = outValid_q;
    outIndex_d   = outIndex_q;
    count_d      = count_q;
    allCovered_d = allCovered_q;

    if (clear) begin
      // Old-epoch pending is forgotten, so an accepted output simply drops.
      seen_d       = '0;
      pending_d    = '0;
      count_d      = '0;
      allCovered_d = 1'b0;
      if (loadEn) begin
        outValid_d = 1'b0;
      end
    end else begin
      if (loadEn) begin
        if (|pending_q) begin
          outValid_d = 1'b1;
          outIndex_d = INDEX_W'(COVER_INDEX) + INDEX_W'(selIdx);
          selMask    = WIDTH'(1) << selIdx;
        end else begin
          outValid_d = 1'b0;
        end
      end
      // newHits are never pending, so setting and clearing cannot collide.
      seen_d       = seen_q | newHits;
      pending_d    = (pending_q & ~selMask) | newHits;
      count_d      = count_q + popCount(newHits);
      allCovered_d = (count_d == CNT_W'(WIDTH));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seen_q       <= '0;
      pending_q    <= '0;
      outValid_q   <= 1'b0;
      outIndex_q   <= '0;
      count_q      <= '0;
      allCovered_q <= 1'b0;
    end else begin
      seen_q       <= seen_d;
      pending_q    <= pending_d;
      outValid_q   <= outValid_d;
      outIndex_q   <= outIndex_d;
      count_q      <= count_d;
      allCovered_q <= allCovered_d;
    end
  end

  assign out_valid     = outValid_q;
  assign out_index     = outIndex_q;
  assign covered_count = count_q;
  assign all_covered   = allCovered_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed, table-driven bench for toggle_cover_collector with COVER_INDEX=100;
// each row drives one cycle of inputs and checks the outputs after that edge.
module tb_toggle_cover_collector;

  localparam int WIDTH   = 32;
  localparam int CIDX    = 100;
  localparam int INDEX_W = 64;
  localparam int CNT_W   = $clog2(WIDTH + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic [WIDTH-1:0]   valid;
  logic               clear;
  logic               out_valid;
  logic               out_ready;
  logic [INDEX_W-1:0] out_index;
  logic [CNT_W-1:0]   covered_count;
  logic               all_covered;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic               rst;
    logic               clr;
    logic               rdy;
    logic [WIDTH-1:0]   vld;
    logic               expValid;
    logic [INDEX_W-1:0] expIndex;
    logic [CNT_W-1:0]   expCount;
    logic               expAll;
  } vec_t;

  vec_t vecs[$];

  toggle_cover_collector #(
    .WIDTH(WIDTH),
    .COVER_INDEX(CIDX),
    .INDEX_W(INDEX_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .valid(valid),
    .clear(clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .covered_count(covered_count),
    .all_covered(all_covered)
  );

  always #5 clock = ~clock;

  task automatic addVec(input logic rst, input logic clr, input logic rdy,
                        input logic [WIDTH-1:0] vld, input logic ev,
                        input int ei, input int ec, input logic ea);
    vec_t v;
    v.rst = rst; v.clr = clr; v.rdy = rdy; v.vld = vld;
    v.expValid = ev; v.expIndex = INDEX_W'(ei);
    v.expCount = CNT_W'(ec); v.expAll = ea;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, then let one rising edge pass.
  task automatic applyStimulus(input logic rst, input logic clr, input logic rdy,
                               input logic [WIDTH-1:0] vld);
    @(negedge clock);
    reset = rst; clear = clr; out_ready = rdy; valid = vld;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int tag,
                             input logic [INDEX_W-1:0] act,
                             input logic [INDEX_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, tag, act, exp);
    end
  endtask

  task automatic checkAll(input int tag, input logic ev, input logic [INDEX_W-1:0] ei,
                          input logic [CNT_W-1:0] ec, input logic ea);
    checkOutput("out_valid", tag, INDEX_W'(out_valid), INDEX_W'(ev));
    checkOutput("out_index", tag, out_index, ei);
    checkOutput("covered_count", tag, INDEX_W'(covered_count), INDEX_W'(ec));
    checkOutput("all_covered", tag, INDEX_W'(all_covered), INDEX_W'(ea));
  endtask

  task automatic runRows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      applyStimulus(vecs[r].rst, vecs[r].clr, vecs[r].rdy, vecs[r].vld);
      checkAll(r, vecs[r].expValid, vecs[r].expIndex, vecs[r].expCount, vecs[r].expAll);
    end
  endtask

  initial begin
    // rst clr rdy valid          ov  index     cnt all
    // single hit on bit 2
    addVec(0, 0, 1, 32'h0000_0004, 0, 0,        1, 0);  // 0
    addVec(0, 0, 1, 32'h0,         1, CIDX+2,   1, 0);
    addVec(0, 0, 1, 32'h0,         0, CIDX+2,   1, 0);
    // burst ordering after a fresh epoch
    addVec(0, 1, 1, 32'h0,         0, CIDX+2,   0, 0);
    addVec(0, 0, 1, 32'h8000_0011, 0, CIDX+2,   3, 0);
    addVec(0, 0, 1, 32'h0,         1, CIDX+0,   3, 0);  // 5
    addVec(0, 0, 1, 32'h0,         1, CIDX+4,   3, 0);
    addVec(0, 0, 1, 32'h0,         1, CIDX+31,  3, 0);
    addVec(0, 0, 1, 32'h0,         0, CIDX+31,  3, 0);
    // backpressure with repeat hits
    addVec(0, 1, 1, 32'h0,         0, CIDX+31,  0, 0);
    addVec(0, 0, 0, 32'h0000_0003, 0, CIDX+31,  2, 0);  // 10
    addVec(0, 0, 0, 32'h0000_0003, 1, CIDX+0,   2, 0);
    addVec(0, 0, 0, 32'h0000_0004, 1, CIDX+0,   3, 0);
    addVec(0, 0, 0, 32'h0000_0003, 1, CIDX+0,   3, 0);
    addVec(0, 0, 1, 32'h0,         1, CIDX+1,   3, 0);
    addVec(0, 0, 1, 32'h0,         1, CIDX+2,   3, 0);  // 15
    addVec(0, 0, 1, 32'h0,         0, CIDX+2,   3, 0);
    addVec(0, 1, 1, 32'h0,         0, CIDX+2,   0, 0);  // 17, before full coverage
    // clear while an index is held
    addVec(0, 1, 1, 32'h0,         0, CIDX+31,  0, 0);  // 18
    addVec(0, 0, 0, 32'h0000_000F, 0, CIDX+31,  4, 0);
    addVec(0, 0, 0, 32'h0,         1, CIDX+0,   4, 0);  // 20
    addVec(0, 1, 0, 32'h0000_0010, 1, CIDX+0,   0, 0);
    addVec(0, 0, 1, 32'h0,         0, CIDX+0,   0, 0);
    addVec(0, 0, 1, 32'h0,         0, CIDX+0,   0, 0);
    addVec(0, 0, 1, 32'h0000_0001, 0, CIDX+0,   1, 0);
    addVec(0, 0, 1, 32'h0,         1, CIDX+0,   1, 0);  // 25
    addVec(0, 0, 1, 32'h0,         0, CIDX+0,   1, 0);
    // reset during operation
    addVec(0, 0, 0, 32'h0000_0007, 0, CIDX+0,   3, 0);
    addVec(0, 0, 0, 32'h0,         1, CIDX+1,   3, 0);
    addVec(1, 0, 0, 32'h0000_00FF, 0, 0,        0, 0);
    addVec(0, 0, 1, 32'h0,         0, 0,        0, 0);  // 30
    addVec(0, 0, 1, 32'h0,         0, 0,        0, 0);
    addVec(0, 0, 1, 32'h0000_0020, 0, 0,        1, 0);
    addVec(0, 0, 1, 32'h0,         1, CIDX+5,   1, 0);
    addVec(0, 0, 1, 32'h0,         0, CIDX+5,   1, 0);  // 34

    reset = 1'b1; clear = 1'b0; out_ready = 1'b0; valid = '1;
    repeat (2) @(posedge clock);
    #1;
    checkAll(-1, 1'b0, '0, '0, 1'b0);

    runRows(0, 17);

    // Full coverage in one cycle, then 32 ascending indices back to back.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF);
    checkAll(100, 1'b0, INDEX_W'(CIDX + 2), CNT_W'(32), 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(0, 0, 1, 32'h0);
      checkAll(101 + i, 1'b1, INDEX_W'(CIDX + i), CNT_W'(32), 1'b1);
    end
    applyStimulus(0, 0, 1, 32'h0);
    checkAll(200, 1'b0, INDEX_W'(CIDX + 31), CNT_W'(32), 1'b1);

    runRows(18, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
